iq_to_phase: RTL and testbench
==============================

IQ_TO_PHASE -- requirements
Module: iq_to_phase

Interface
REQ-001 Parameter PHASE_DW, default 16, output phase width; full circle = 2^PHASE_DW counts.
REQ-002 Parameter IN_DW, default 16, width of each signed I/Q input component.
REQ-003 Parameter ITERATIONS, default 16, number of CORDIC vectoring iterations (range 4..PHASE_DW).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 s_axis_in_tdata  in  2*IN_DW  {sin (upper, signed), cos (lower, signed)}, same packing as the DDS combined output.
REQ-008 s_axis_in_tvalid  in  1  input sample valid.
REQ-009 s_axis_in_tready  out  1  block can accept a sample.
REQ-010 m_axis_phase_tdata  out  PHASE_DW  unsigned phase, same encoding as the DDS phase input.
REQ-011 m_axis_phase_tvalid  out  1  phase result valid.
REQ-012 m_axis_phase_tready  in  1  downstream accepts the result.

Function
REQ-013 Output SHALL be atan2(sin, cos) mapped to [0, 2^PHASE_DW): 0 rad = 0, pi/2 = 2^(PHASE_DW-2), pi = 2^(PHASE_DW-1); wrap modulo 2^PHASE_DW.
REQ-014 FSM states SHALL be IDLE, ROTATE and DONE.
REQ-015 Transitions: IDLE->ROTATE on tvalid&&tready; ROTATE->DONE when the iteration counter reaches ITERATIONS-1; DONE->IDLE on m_axis_phase_tready.
REQ-016 s_axis_in_tready SHALL be 1 only in IDLE; m_axis_phase_tvalid SHALL be 1 only in DONE.
REQ-017 On accept: x = cos, y = sin, sign-extended to IN_DW+2 bits; z = 0.
REQ-018 On accept, if cos < 0: x and y SHALL be negated and z = 2^(PHASE_DW-1); guard bits make negation of the most negative input exact.
REQ-019 Iteration i with y >= 0: x += y>>>i, y -= x>>>i, z += ATAN[i].
REQ-020 Iteration i with y < 0: x -= y>>>i, y += x>>>i, z -= ATAN[i].
REQ-021 Shifts SHALL be arithmetic; all updates SHALL use pre-iteration values.
REQ-022 ATAN[i] = round(atan(2^-i) * 2^PHASE_DW / (2*pi)), z width PHASE_DW, modular arithmetic.
REQ-023 Latency: sample accepted at edge k -> m_axis_phase_tvalid high after edge k+ITERATIONS.
REQ-024 Throughput: one sample per ITERATIONS+1 cycles, plus any back-pressure cycles.
REQ-025 In DONE, m_axis_phase_tdata SHALL hold stable until accepted.
REQ-026 m_axis_phase_tdata SHALL be registered z.
REQ-027 Input (0,0) SHALL produce phase 0.
REQ-028 Accuracy: |error| <= 4 LSB for amplitude >= 2^(IN_DW-2) at default parameters.
REQ-029 s_axis_in_tdata SHALL be ignored outside IDLE.

Reset
REQ-030 While reset is asserted: state = IDLE, counter = 0, x/y/z = 0, m_axis_phase_tdata = 0, m_axis_phase_tvalid = 0.
REQ-031 While reset is asserted, s_axis_in_tready SHALL be 0; it SHALL go to 1 on the first clock edge after reset deasserts.
REQ-032 Reset during ROTATE or DONE SHALL discard the sample, with no output produced.

Structure
REQ-033 The ATAN table generation function and the state enum type SHALL reside in shared package dds_pkg.
REQ-034 The ATAN ROM SHALL be sub-module cordic_atan_rom (parameters PHASE_DW, ITERATIONS; combinational index-to-constant lookup).

Verification
REQ-035 Axis points: (0,32767)->0x0000; (32767,0)->0x4000; (0,-32767)->0x8000; (-32767,0)->0xC000; each +/-4 LSB.
REQ-036 Diagonal (sin,cos) = (-23170,23170) -> 0xE000 +/-4; extreme (-32768,-32768) -> 0xA000 +/-4, with no overflow.
REQ-037 Latency: one sample accepted at cycle 10 with m_tready = 1 -> tvalid at cycle 26, tready back to 1 at cycle 27.
REQ-038 Back-pressure: m_tready = 0 for 20 cycles -> tdata stable and tready low throughout; exactly one transfer on release.
REQ-039 Loopback: DDS (PHASE_DW=16, SIN_COS=1) driven with phases 0..65535 step 97 -> recovered phase within +/-4 LSB (modular).
REQ-040 Reset asserted mid-ROTATE -> no tvalid; the next sample (32767,0) returns 0x4000.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS/CORDIC definitions: converter FSM state type and the arctangent table generator.
package dds_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRotate,
        StDone
    } cordic_state_e;

    // atan(2^-i) as a fraction of a full circle, scaled by 2^32 and rounded.
    localparam logic [31:0] ATAN_2P32 [32] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
    };

    function automatic logic [31:0] atan_entry(input int unsigned idx,
                                               input int unsigned phase_dw);
        logic [32:0] raw;
        if (idx >= 32) begin
            return '0;
        end
        raw = {1'b0, ATAN_2P32[idx[4:0]]};
        if (phase_dw >= 32) begin
            return raw[31:0];
        end
        raw = raw + (33'd1 << (31 - phase_dw));
        return 32'(raw >> (32 - phase_dw));
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of the CORDIC rotation angle for iteration idx_i.
module cordic_atan_rom
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_DW   = 16,
    parameter int unsigned ITERATIONS = 16,
    localparam int unsigned IdxW      = $clog2(ITERATIONS)
) (
    input  logic [IdxW-1:0]     idx_i,
    output logic [PHASE_DW-1:0] atan_o
);

    logic [PHASE_DW-1:0] atan_tbl [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_tbl
        assign atan_tbl[g] = PHASE_DW'(atan_entry(g, PHASE_DW));
    end

    always_comb begin
        atan_o = '0;
        if (32'(idx_i) < ITERATIONS) begin
            atan_o = atan_tbl[idx_i];
        end
    end

endmodule

// File: rtl/iq_to_phase.sv
// Iterative CORDIC vectoring: converts a {sin, cos} sample into an unsigned full-circle phase.
module iq_to_phase
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_DW   = 16,
    parameter int unsigned IN_DW      = 16,
    parameter int unsigned ITERATIONS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*IN_DW-1:0]    s_axis_in_tdata,
    input  logic                  s_axis_in_tvalid,
    output logic                  s_axis_in_tready,
    output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
    output logic                  m_axis_phase_tvalid,
    input  logic                  m_axis_phase_tready
);

    localparam int unsigned XW   = IN_DW + 2;
    localparam int unsigned CntW = $clog2(ITERATIONS);
    localparam logic [CntW-1:0] LastIter = CntW'(ITERATIONS - 1);

    cordic_state_e          state_q;
    logic [CntW-1:0]        cnt_q;
    logic signed [XW-1:0]   x_q, y_q;
    logic [PHASE_DW-1:0]    z_q;
    logic                   zero_q;
    logic                   tready_q, tvalid_q;

    logic signed [IN_DW-1:0] sin_in, cos_in;
    logic signed [XW-1:0]    sin_ext, cos_ext;
    logic signed [XW-1:0]    x_init, y_init;
    logic [PHASE_DW-1:0]     z_init;
    logic                    zero_in;

    logic signed [XW-1:0]    x_sh, y_sh, x_d, y_d;
    logic [PHASE_DW-1:0]     z_d, atan_val;

    assign sin_in  = s_axis_in_tdata[2*IN_DW-1:IN_DW];
    assign cos_in  = s_axis_in_tdata[IN_DW-1:0];
    assign sin_ext = XW'(sin_in);
    assign cos_ext = XW'(cos_in);
    assign zero_in = (sin_in == '0) && (cos_in == '0);

    // Fold the left half-plane onto the right so vectoring converges; guard bits keep -(-2^(N-1)).
    always_comb begin
        x_init = cos_ext;
        y_init = sin_ext;
        z_init = '0;
        if (cos_in < 0) begin
            x_init = -cos_ext;
            y_init = -sin_ext;
            z_init = {1'b1, {(PHASE_DW-1){1'b0}}};
        end
    end

    cordic_atan_rom #(
        .PHASE_DW   (PHASE_DW),
        .ITERATIONS (ITERATIONS)
    ) u_atan_rom (
        .idx_i  (cnt_q),
        .atan_o (atan_val)
    );

    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (!y_q[XW-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_val;
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            zero_q   <= 1'b0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tready_q <= 1'b1;
                    if (s_axis_in_tvalid && tready_q) begin
                        state_q  <= StRotate;
                        tready_q <= 1'b0;
                        cnt_q    <= '0;
                        x_q      <= x_init;
                        y_q      <= y_init;
                        z_q      <= z_init;
                        zero_q   <= zero_in;
                    end
                end
                StRotate: begin
                    // A (0,0) sample has no direction; hold z at zero instead of drifting.
                    if (!zero_q) begin
                        x_q <= x_d;
                        y_q <= y_d;
                        z_q <= z_d;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_q  <= StDone;
                        cnt_q    <= '0;
                        tvalid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (m_axis_phase_tready) begin
                        state_q  <= StIdle;
                        tvalid_q <= 1'b0;
                        tready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    tvalid_q <= 1'b0;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_axis_in_tready    = tready_q;
    assign m_axis_phase_tvalid = tvalid_q;
    assign m_axis_phase_tdata  = z_q;

endmodule

// File: tb/tb_iq_to_phase.sv
// Directed and randomized checks of iq_to_phase against an atan2-based reference.
module tb_iq_to_phase;

    localparam int unsigned PW = 16;
    localparam int unsigned IW = 16;
    localparam int unsigned IT = 16;
    localparam real PI = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [2*IW-1:0] s_tdata = '0;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [PW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready = 1'b1;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    iq_to_phase #(
        .PHASE_DW   (PW),
        .IN_DW      (IW),
        .ITERATIONS (IT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_in_tdata     (s_tdata),
        .s_axis_in_tvalid    (s_tvalid),
        .s_axis_in_tready    (s_tready),
        .m_axis_phase_tdata  (m_tdata),
        .m_axis_phase_tvalid (m_tvalid),
        .m_axis_phase_tready (m_tready)
    );

    function automatic logic [PW-1:0] atan_ref(input int s, input int c);
        real r;
        int  v;
        if (s == 0 && c == 0) return '0;
        r = $atan2(real'(s), real'(c)) * 65536.0 / (2.0 * PI);
        if (r < 0.0) r = r + 65536.0;
        v = int'(r);
        return PW'(v % 65536);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_phase(input string tag, input logic [PW-1:0] got,
                               input logic [PW-1:0] exp, input int tol);
        logic [PW-1:0] d;
        int            sd;
        logic          ok;
        d  = got - exp;
        sd = int'($signed(d));
        ok = (sd <= tol) && (sd >= -tol);
        n_vec++;
        assert (ok === 1'b1) else begin
            n_miss++;
            $error("FAIL %s: observed phase 0x%0h expected 0x%0h +/-%0d", tag, got, exp, tol);
        end
    endtask

    task automatic send(input int s, input int c);
        s_tdata  = {IW'(s), IW'(c)};
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
    endtask

    task automatic wait_valid(output logic [PW-1:0] ph, output int lat);
        lat = 0;
        while (!m_tvalid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ph = m_tdata;
    endtask

    task automatic check_sample(input string tag, input int s, input int c,
                                input logic [PW-1:0] exp, input int tol);
        logic [PW-1:0] ph;
        int            lat;
        check({tag, "_tready"}, 64'(s_tready), 64'd1);
        send(s, c);
        wait_valid(ph, lat);
        check({tag, "_latency"}, 64'(lat), 64'(IT));
        check_phase(tag, ph, exp, tol);
        @(posedge clk);
        #1;
        check({tag, "_ack"}, {62'd0, s_tready, m_tvalid}, 64'b10);
    endtask

    initial begin
        logic [PW-1:0] ph;
        logic [PW-1:0] hold;
        int            lat;
        int            xfers;
        int            seen;
        int            s, c, a;
        real           ang;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {61'd0, s_tready, m_tvalid, |m_tdata}, 64'd0);
        reset = 1'b0;
        #1;
        check("rst_release_tready", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        check("tready_after_rst", 64'(s_tready), 64'd1);

        check_sample("axis_0",    0,      32767,  16'h0000, 4);
        check_sample("axis_90",   32767,  0,      16'h4000, 4);
        check_sample("axis_180",  0,      -32767, 16'h8000, 4);
        check_sample("axis_270",  -32767, 0,      16'hC000, 4);
        check_sample("diag_315",  -23170, 23170,  16'hE000, 4);
        check_sample("extreme",   -32768, -32768, 16'hA000, 4);
        check_sample("zero_in",   0,      0,      16'h0000, 0);

        // Back-pressure: result must hold while downstream stalls.
        m_tready = 1'b0;
        send(12000, -5000);
        wait_valid(ph, lat);
        check("bp_latency", 64'(lat), 64'(IT));
        check_phase("bp_phase", ph, atan_ref(12000, -5000), 4);
        hold = ph;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("bp_hold", {46'd0, s_tready, m_tvalid, m_tdata}, {46'd0, 1'b0, 1'b1, hold});
        end
        m_tready = 1'b1;
        xfers = 0;
        repeat (5) begin
            if (m_tvalid && m_tready) xfers++;
            @(posedge clk);
            #1;
        end
        check("bp_transfers", 64'(xfers), 64'd1);

        // Reset while rotating discards the sample.
        send(100, 200);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_outputs", {45'd0, s_tready, m_tvalid, m_tdata}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (m_tvalid) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);
        check_sample("post_rst", 32767, 0, 16'h4000, 4);

        for (int k = 0; k < 60; k++) begin
            a   = int'($urandom_range(32767, 16384));
            ang = 2.0 * PI * real'($urandom_range(65535, 0)) / 65536.0;
            s   = int'(real'(a) * $sin(ang));
            c   = int'(real'(a) * $cos(ang));
            check_sample("random", s, c, atan_ref(s, c), 4);
        end

        for (int p = 0; p < 65536; p += 97) begin
            ang = 2.0 * PI * real'(p) / 65536.0;
            s   = int'(32767.0 * $sin(ang));
            c   = int'(32767.0 * $cos(ang));
            check_sample("loopback", s, c, PW'(p), 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
